muldiv_unit: RTL

Parametrised iterative multiply/divide unit for the MIPS execute stage, producing the HI/LO pair for MULT, MULTU, DIV and DIVU. It generalises the combinational adder into a WIDTH-bit radix-2 sequential datapath (one shift-add or shift-subtract step per clock) with a start/busy/done handshake. Hazard logic stalls the pipeline on `busy`. MFHI/MFLO read `hi`/`lo` directly; MTHI/MTLO write them through `hi_we`/`lo_we`.

---
 rtl/muldiv_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit producing the MIPS HI/LO pair.
// One shift-add (MULT/MULTU) or restoring shift-subtract (DIV/DIVU) step per clock.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_hi_we,
    input  logic             i_lo_we,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_zero,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic               r_is_div, r_neg_q, r_neg_r, r_dz;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic               r_div_zero;

    logic               w_accept, w_last, w_sgn, w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b;
    logic [WIDTH:0]     w_mul_sum, w_div_cand, w_div_diff;
    logic               w_div_ok;
    logic [2*WIDTH-1:0] w_mul_nxt, w_div_nxt, w_acc_nxt, w_prod;
    logic [WIDTH-1:0]   w_quo, w_rem, w_res_hi, w_res_lo;

    assign w_accept = i_start && (r_state != S_CALC);
    assign w_last   = (r_state == S_CALC) && (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_CALC;
            S_CALC:  if (w_last)  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = i_start ? S_CALC : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // op[0]=0 selects the signed variants; the datapath only ever sees magnitudes
    assign w_sgn   = ~i_op[0];
    assign w_a_neg = w_sgn & i_a[WIDTH-1];
    assign w_b_neg = w_sgn & i_b[WIDTH-1];
    assign w_abs_a = w_a_neg ? -i_a : i_a;
    assign w_abs_b = w_b_neg ? -i_b : i_b;

    // Multiply: {partial, multiplier} shifts right, adding the multiplicand on a 1 bit
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: {remainder, dividend/quotient} shifts left, quotient bits enter at the bottom
    assign w_div_cand = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_diff = w_div_cand - {1'b0, r_opnd};
    assign w_div_ok   = ~w_div_diff[WIDTH];
    assign w_div_nxt  = {(w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_cand[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_div_ok};

    assign w_acc_nxt = r_is_div ? w_div_nxt : w_mul_nxt;
    assign w_prod    = r_neg_q ? -w_acc_nxt : w_acc_nxt;
    assign w_quo     = w_acc_nxt[WIDTH-1:0];
    assign w_rem     = w_acc_nxt[2*WIDTH-1:WIDTH];

    // With b=0 the remainder ends up as |a|, so re-signing it restores the original a
    assign w_res_lo = r_is_div ? (r_dz ? '1 : (r_neg_q ? -w_quo : w_quo)) : w_prod[WIDTH-1:0];
    assign w_res_hi = r_is_div ? (r_neg_r ? -w_rem : w_rem) : w_prod[2*WIDTH-1:WIDTH];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dz       <= 1'b0;
            r_opnd     <= '0;
            r_acc      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_zero <= 1'b0;
        end else begin
            if (w_accept) begin
                r_is_div <= i_op[1];
                r_opnd   <= i_op[1] ? w_abs_b : w_abs_a;
                r_acc    <= {{WIDTH{1'b0}}, (i_op[1] ? w_abs_a : w_abs_b)};
                r_neg_q  <= w_a_neg ^ w_b_neg;
                r_neg_r  <= w_a_neg;
                r_dz     <= i_op[1] && (i_b == '0);
                r_cnt    <= '0;
            end else if (r_state == S_CALC) begin
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt + CW'(1);
            end

            if (w_last) begin
                r_hi       <= w_res_hi;
                r_lo       <= w_res_lo;
                r_div_zero <= r_is_div & r_dz;
            end else if (r_state != S_CALC) begin
                if (i_hi_we) r_hi <= i_wdata;
                if (i_lo_we) r_lo <= i_wdata;
            end
        end
    end

    assign o_busy     = (r_state == S_CALC);
    assign o_done     = (r_state == S_DONE);
    assign o_div_zero = r_div_zero;
    assign o_hi       = r_hi;
    assign o_lo       = r_lo;
endmodule
